// File: rtl/neander_control.sv
// Neander control unit: fetch/decode/execute sequencer.
// Drives datapath strobes from state, opcode and stored N/Z flags.
module neander_control (
    input  logic       clock,
    input  logic       nreset,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       flag_n,
    input  logic       flag_z,
    output logic [1:0] usel,
    output logic       ac_src,
    output logic       ac_load,
    output logic       nz_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       rem_load,
    output logic       rem_sel,
    output logic       rdm_load,
    output logic       rdm_src,
    output logic       ri_load,
    output logic       mem_read,
    output logic       mem_write,
    output logic       halted,
    output logic [3:0] sstate
);

    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        T7   = 4'd7,
        HALT = 4'd8
    } state_t;

    state_t state, state_nx;

    logic op_mem, op_jmp, jmp_skip, op_mem_path;

    assign op_mem   = (opcode >= 4'h1) && (opcode <= 4'h5);
    assign op_jmp   = (opcode == 4'h8) || (opcode == 4'h9) || (opcode == 4'hA);
    assign jmp_skip = ((opcode == 4'h9) && !flag_n)
                   || ((opcode == 4'hA) && !flag_z);
    // Instructions that fetch an operand address in T4.
    assign op_mem_path = op_mem || (op_jmp && !jmp_skip);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) state <= T0;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            T0:      state_nx = run ? T1 : T0;
            T1:      state_nx = T2;
            T2:      state_nx = T3;
            T3: begin
                if (opcode == 4'hF)  state_nx = HALT;
                else if (op_mem_path) state_nx = T4;
                else                  state_nx = T0;
            end
            T4:      state_nx = T5;
            T5:      state_nx = op_jmp ? T0 : T6;
            T6:      state_nx = T7;
            T7:      state_nx = T0;
            HALT:    state_nx = HALT;
            default: state_nx = T0;
        endcase
    end

    always_comb begin
        usel      = 2'b00;
        ac_src    = 1'b0;
        ac_load   = 1'b0;
        nz_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        rem_load  = 1'b0;
        rem_sel   = 1'b0;
        rdm_load  = 1'b0;
        rdm_src   = 1'b0;
        ri_load   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        halted    = 1'b0;
        sstate    = nreset ? state : T0;
        if (nreset) begin
            unique case (state)
                T0: rem_load = run;
                T1: begin
                    mem_read = 1'b1;
                    rdm_load = 1'b1;
                    pc_inc   = 1'b1;
                end
                T2: ri_load = 1'b1;
                T3: begin
                    unique case (1'b1)
                        opcode == 4'h6: begin
                            usel    = 2'b11;
                            ac_load = 1'b1;
                            nz_load = 1'b1;
                        end
                        jmp_skip:    pc_inc   = 1'b1;
                        op_mem_path: rem_load = 1'b1;
                        default: ;
                    endcase
                end
                T4: begin
                    mem_read = 1'b1;
                    rdm_load = 1'b1;
                    pc_inc   = !op_jmp;
                end
                T5: begin
                    pc_load  = op_jmp;
                    rem_load = !op_jmp;
                    rem_sel  = !op_jmp;
                end
                T6: begin
                    rdm_load = 1'b1;
                    rdm_src  = (opcode == 4'h1);
                    mem_read = (opcode != 4'h1);
                end
                T7: begin
                    unique case (1'b1)
                        opcode == 4'h1: mem_write = 1'b1;
                        opcode == 4'h2: begin
                            ac_src  = 1'b1;
                            ac_load = 1'b1;
                            nz_load = 1'b1;
                        end
                        opcode == 4'h3,
                        opcode == 4'h4,
                        opcode == 4'h5: begin
                            usel    = (opcode == 4'h4) ? 2'b10
                                    : (opcode == 4'h5) ? 2'b01 : 2'b00;
                            ac_load = 1'b1;
                            nz_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
